// File: rtl/feature_map_streamer.sv
// Streams one feature map from synchronous memory: each channel plane is read
// row-major on its own lane and presented with valid/hold flow control.
module feature_map_streamer #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int N_ROWS     = 28,
    parameter int N_COLS     = 28,
    parameter int N_CHANNELS = 3,
    parameter int BASE_ADDR  = 0
) (
    input  logic                             clock_i,
    input  logic                             reset_ni,
    input  logic                             start_i,
    input  logic [N_CHANNELS-1:0]            hold_data_i,
    input  logic [N_CHANNELS*DATA_WIDTH-1:0] mem_data_i,
    output logic [N_CHANNELS-1:0]            mem_rd_en_o,
    output logic [N_CHANNELS*ADDR_WIDTH-1:0] mem_addr_o,
    output logic [N_CHANNELS-1:0]            data_valid_o,
    output logic [N_CHANNELS*DATA_WIDTH-1:0] data_o,
    output logic                             busy_o,
    output logic                             done_o
);
    localparam int PLANE = N_ROWS * N_COLS;
    localparam int CNT_W = $clog2(PLANE + 1);
    localparam logic [CNT_W-1:0] PLANE_C = CNT_W'(PLANE);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(PLANE - 1);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  w_start;
    logic                  w_streaming;
    logic [N_CHANNELS-1:0] w_lane_fin;

    assign w_start     = (r_state == ST_IDLE) && start_i;
    assign w_streaming = (r_state == ST_STREAM);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of the order blocks are evaluated.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_state_next = ST_STREAM;
                end
            end
            ST_STREAM: begin
                busy_o = 1'b1;
                if (&w_lane_fin) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done_o       = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    for (genvar c = 0; c < N_CHANNELS; c++) begin : g_lane
        localparam logic [ADDR_WIDTH-1:0] LANE_BASE = ADDR_WIDTH'(BASE_ADDR + c * PLANE);

        logic [CNT_W-1:0]      r_idx;
        logic [CNT_W-1:0]      r_acc;
        logic                  r_inflight;
        logic [DATA_WIDTH-1:0] r_fifo [2];
        logic                  r_rd_ptr;
        logic                  r_wr_ptr;
        logic [1:0]            r_count;

        logic [DATA_WIDTH-1:0] w_in_data;
        logic [DATA_WIDTH-1:0] w_head;
        logic                  w_valid;
        logic                  w_pop;
        logic                  w_fifo_pop;
        logic                  w_push;
        logic                  w_issue;
        logic [1:0]            w_occ_after;

        assign w_in_data = mem_data_i[c*DATA_WIDTH +: DATA_WIDTH];

        // The returning read word counts as a FIFO entry in the cycle it lands,
        // which gives the two-cycle start-to-valid latency without a bubble.
        assign w_valid    = (r_count != 2'd0) || r_inflight;
        assign w_head     = (r_count != 2'd0) ? r_fifo[r_rd_ptr] :
                            (r_inflight ? w_in_data : '0);
        assign w_pop      = w_valid && !hold_data_i[c];
        assign w_fifo_pop = w_pop && (r_count != 2'd0);
        assign w_push     = r_inflight && !(w_pop && (r_count == 2'd0));

        assign w_occ_after = r_count + {1'b0, r_inflight} - {1'b0, w_pop};
        assign w_issue     = w_streaming && (r_idx < PLANE_C) && (w_occ_after < 2'd2);

        assign w_lane_fin[c] = (r_acc == PLANE_C) || ((r_acc == LAST_C) && w_pop);

        always_ff @(posedge clock_i or negedge reset_ni) begin
            if (!reset_ni) begin
                r_idx      <= '0;
                r_acc      <= '0;
                r_inflight <= 1'b0;
                r_rd_ptr   <= 1'b0;
                r_wr_ptr   <= 1'b0;
                r_count    <= 2'd0;
            end else if (w_start) begin
                r_idx      <= '0;
                r_acc      <= '0;
                r_inflight <= 1'b0;
                r_rd_ptr   <= 1'b0;
                r_wr_ptr   <= 1'b0;
                r_count    <= 2'd0;
            end else begin
                r_inflight <= w_issue;
                if (w_issue) begin
                    r_idx <= r_idx + ONE_C;
                end
                if (w_pop) begin
                    r_acc <= r_acc + ONE_C;
                end
                if (w_push) begin
                    r_wr_ptr <= ~r_wr_ptr;
                end
                if (w_fifo_pop) begin
                    r_rd_ptr <= ~r_rd_ptr;
                end
                r_count <= r_count + {1'b0, w_push} - {1'b0, w_fifo_pop};
            end
        end

        // NOTE: FIFO storage is not reset; r_count gates every read of it, so
        // stale contents are never visible and the array stays plain RAM.
        always_ff @(posedge clock_i) begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= w_in_data;
            end
        end

        assign mem_rd_en_o[c]                       = w_issue;
        assign mem_addr_o[c*ADDR_WIDTH +: ADDR_WIDTH] =
            w_issue ? (LANE_BASE + ADDR_WIDTH'(r_idx)) : '0;
        assign data_valid_o[c]                      = w_valid;
        assign data_o[c*DATA_WIDTH +: DATA_WIDTH]   = w_head;
    end

endmodule

// File: tb/tb_feature_map_streamer.sv
// Scoreboard bench for feature_map_streamer: a small 4x4x2 instance for the
// directed scenarios and a default 28x28x3 instance for random holds.
module tb_feature_map_streamer;
    localparam int AW      = 16;
    localparam int DW      = 32;
    localparam int A_CH    = 2;
    localparam int A_PLANE = 16;
    localparam int A_BASE  = 'h100;
    localparam int B_CH    = 3;
    localparam int B_PLANE = 784;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc         = 0;
    int vectors     = 0;
    int miscompares = 0;

    logic                 a_rst_n, a_start;
    logic [A_CH-1:0]      a_hold;
    logic [A_CH*DW-1:0]   a_mem_data = '0;
    logic [A_CH-1:0]      a_rd_en, a_valid;
    logic [A_CH*AW-1:0]   a_addr;
    logic [A_CH*DW-1:0]   a_data;
    logic                 a_busy, a_done;

    logic                 b_rst_n, b_start;
    logic [B_CH-1:0]      b_hold;
    logic [B_CH*DW-1:0]   b_mem_data = '0;
    logic [B_CH-1:0]      b_rd_en, b_valid;
    logic [B_CH*AW-1:0]   b_addr;
    logic [B_CH*DW-1:0]   b_data;
    logic                 b_busy, b_done;

    feature_map_streamer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_ROWS(4), .N_COLS(4),
        .N_CHANNELS(A_CH), .BASE_ADDR(A_BASE)
    ) dut_a (
        .clock_i(clk), .reset_ni(a_rst_n), .start_i(a_start), .hold_data_i(a_hold),
        .mem_data_i(a_mem_data), .mem_rd_en_o(a_rd_en), .mem_addr_o(a_addr),
        .data_valid_o(a_valid), .data_o(a_data), .busy_o(a_busy), .done_o(a_done)
    );

    feature_map_streamer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_ROWS(28), .N_COLS(28),
        .N_CHANNELS(B_CH), .BASE_ADDR(0)
    ) dut_b (
        .clock_i(clk), .reset_ni(b_rst_n), .start_i(b_start), .hold_data_i(b_hold),
        .mem_data_i(b_mem_data), .mem_rd_en_o(b_rd_en), .mem_addr_o(b_addr),
        .data_valid_o(b_valid), .data_o(b_data), .busy_o(b_busy), .done_o(b_done)
    );

    // Synchronous memories whose word equals its address.
    always @(posedge clk) begin
        for (int c = 0; c < A_CH; c++)
            if (a_rd_en[c]) a_mem_data[c*DW +: DW] <= {16'h0, a_addr[c*AW +: AW]};
    end
    always @(posedge clk) begin
        for (int c = 0; c < B_CH; c++)
            if (b_rd_en[c]) b_mem_data[c*DW +: DW] <= {16'h0, b_addr[c*AW +: AW]};
    end

    logic [31:0] a_q [A_CH][$];
    logic [31:0] b_q [B_CH][$];
    logic [15:0] a_exp_addr [A_CH];
    logic [15:0] b_exp_addr [B_CH];
    int a_issued [A_CH], a_acc [A_CH], a_last_acc [A_CH];
    int b_issued [B_CH], b_acc [B_CH], b_last_acc [B_CH];
    logic a_held [A_CH];
    logic b_held [B_CH];
    logic [31:0] a_held_data [A_CH];
    logic [31:0] b_held_data [B_CH];
    int a_done_cnt, a_done_cyc, a_first_valid;
    int b_done_cnt, b_done_cyc, b_first_valid;

    task automatic arm_a();
        for (int c = 0; c < A_CH; c++) begin
            a_q[c].delete();
            for (int i = 0; i < A_PLANE; i++) a_q[c].push_back(32'(A_BASE + c*A_PLANE + i));
            a_exp_addr[c] = 16'(A_BASE + c*A_PLANE);
            a_issued[c] = 0; a_acc[c] = 0; a_last_acc[c] = -1; a_held[c] = 1'b0;
        end
        a_done_cnt = 0; a_done_cyc = -1; a_first_valid = -1;
    endtask

    task automatic arm_b();
        for (int c = 0; c < B_CH; c++) begin
            b_q[c].delete();
            for (int i = 0; i < B_PLANE; i++) b_q[c].push_back(32'(c*B_PLANE + i));
            b_exp_addr[c] = 16'(c*B_PLANE);
            b_issued[c] = 0; b_acc[c] = 0; b_last_acc[c] = -1; b_held[c] = 1'b0;
        end
        b_done_cnt = 0; b_done_cyc = -1; b_first_valid = -1;
    endtask

    // One clock cycle: sample both DUTs mid-cycle against the scoreboard,
    // then advance past the rising edge.
    task automatic tick();
        logic [31:0] d, exp_d;
        @(negedge clk);
        for (int c = 0; c < A_CH; c++) begin
            d = a_data[c*DW +: DW];
            if (a_rd_en[c]) begin
                vectors++;
                if (a_issued[c] >= A_PLANE || a_addr[c*AW +: AW] !== a_exp_addr[c]) begin
                    miscompares++;
                    $display("FAIL a_issue lane%0d cyc%0d: addr 0x%0h, expected 0x%0h (issued %0d of %0d)",
                             c, cyc, a_addr[c*AW +: AW], a_exp_addr[c], a_issued[c], A_PLANE);
                end
                a_exp_addr[c]++; a_issued[c]++;
            end
            if (a_valid[c] && a_first_valid < 0) a_first_valid = cyc;
            if (a_held[c] && a_valid[c]) begin
                vectors++;
                if (d !== a_held_data[c]) begin
                    miscompares++;
                    $display("FAIL a_hold_stable lane%0d cyc%0d: data 0x%0h, expected 0x%0h", c, cyc, d, a_held_data[c]);
                end
            end
            a_held[c] = a_valid[c] && a_hold[c];
            a_held_data[c] = d;
            if (!a_valid[c]) begin
                vectors++;
                if (d !== 32'h0) begin
                    miscompares++;
                    $display("FAIL a_empty_data lane%0d cyc%0d: data 0x%0h, expected 0x0", c, cyc, d);
                end
            end else if (!a_hold[c]) begin
                vectors++;
                if (a_q[c].size() == 0) begin
                    miscompares++;
                    $display("FAIL a_extra_word lane%0d cyc%0d: data 0x%0h, expected no word", c, cyc, d);
                end else begin
                    exp_d = a_q[c].pop_front();
                    if (d !== exp_d) begin
                        miscompares++;
                        $display("FAIL a_data lane%0d cyc%0d: data 0x%0h, expected 0x%0h", c, cyc, d, exp_d);
                    end
                end
                a_acc[c]++; a_last_acc[c] = cyc;
            end
        end
        if (a_done) begin
            a_done_cnt++; a_done_cyc = cyc;
            vectors++;
            if (a_q[0].size() + a_q[1].size() != 0) begin
                miscompares++;
                $display("FAIL a_done_partial cyc%0d: %0d words pending, expected 0", cyc, a_q[0].size() + a_q[1].size());
            end
        end
        for (int c = 0; c < B_CH; c++) begin
            d = b_data[c*DW +: DW];
            if (b_rd_en[c]) begin
                vectors++;
                if (b_issued[c] >= B_PLANE || b_addr[c*AW +: AW] !== b_exp_addr[c]) begin
                    miscompares++;
                    $display("FAIL b_issue lane%0d cyc%0d: addr 0x%0h, expected 0x%0h (issued %0d of %0d)",
                             c, cyc, b_addr[c*AW +: AW], b_exp_addr[c], b_issued[c], B_PLANE);
                end
                b_exp_addr[c]++; b_issued[c]++;
            end
            if (b_valid[c] && b_first_valid < 0) b_first_valid = cyc;
            if (b_held[c] && b_valid[c]) begin
                vectors++;
                if (d !== b_held_data[c]) begin
                    miscompares++;
                    $display("FAIL b_hold_stable lane%0d cyc%0d: data 0x%0h, expected 0x%0h", c, cyc, d, b_held_data[c]);
                end
            end
            b_held[c] = b_valid[c] && b_hold[c];
            b_held_data[c] = d;
            if (b_valid[c] && !b_hold[c]) begin
                vectors++;
                if (b_q[c].size() == 0) begin
                    miscompares++;
                    $display("FAIL b_extra_word lane%0d cyc%0d: data 0x%0h, expected no word", c, cyc, d);
                end else begin
                    exp_d = b_q[c].pop_front();
                    if (d !== exp_d) begin
                        miscompares++;
                        $display("FAIL b_data lane%0d cyc%0d: data 0x%0h, expected 0x%0h", c, cyc, d, exp_d);
                    end
                end
                b_acc[c]++; b_last_acc[c] = cyc;
            end
        end
        if (b_done) begin
            b_done_cnt++; b_done_cyc = cyc;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic pulse_start_a(output int s);
        a_start = 1'b1; s = cyc;
        tick();
        a_start = 1'b0;
    endtask

    task automatic test_reset();
        a_rst_n = 1'b0; b_rst_n = 1'b0; a_start = 1'b0; b_start = 1'b0;
        a_hold = '0; b_hold = '0;
        arm_a(); arm_b();
        for (int c = 0; c < A_CH; c++) a_q[c].delete();
        for (int c = 0; c < B_CH; c++) b_q[c].delete();
        #3;
        vectors++;
        if ({a_rd_en, a_addr, a_valid, a_data, a_busy, a_done} !== '0) begin
            miscompares++;
            $display("FAIL reset_a_outputs: got 0x%0h, expected 0", {a_rd_en, a_addr, a_valid, a_data, a_busy, a_done});
        end
        vectors++;
        if ({b_rd_en, b_addr, b_valid, b_data, b_busy, b_done} !== '0) begin
            miscompares++;
            $display("FAIL reset_b_outputs: got 0x%0h, expected 0", {b_rd_en, b_addr, b_valid, b_data, b_busy, b_done});
        end
        tick(); tick();
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        tick();
        vectors++;
        if ({a_busy, a_done, a_rd_en, a_valid} !== '0) begin
            miscompares++;
            $display("FAIL idle_after_reset: got 0x%0h, expected 0", {a_busy, a_done, a_rd_en, a_valid});
        end
    endtask

    task automatic test_basic_stream();
        int s, n;
        arm_a();
        pulse_start_a(s);
        vectors++;
        if (a_busy !== 1'b1 || a_rd_en !== 2'b11 || a_addr !== {16'h0110, 16'h0100}) begin
            miscompares++;
            $display("FAIL basic_first_issue: busy %b rd_en %b addr 0x%0h, expected 1 11 0x01100100", a_busy, a_rd_en, a_addr);
        end
        n = 0;
        while (a_done_cnt == 0 && n < 100) begin tick(); n++; end
        repeat (3) tick();
        vectors++;
        if (a_first_valid !== s + 2) begin
            miscompares++;
            $display("FAIL basic_first_valid: cycle %0d, expected %0d", a_first_valid, s + 2);
        end
        vectors++;
        if (a_last_acc[0] !== s + 17 || a_last_acc[1] !== s + 17) begin
            miscompares++;
            $display("FAIL basic_last_accept: %0d/%0d, expected %0d", a_last_acc[0], a_last_acc[1], s + 17);
        end
        vectors++;
        if (a_done_cnt !== 1 || a_done_cyc !== s + 18) begin
            miscompares++;
            $display("FAIL basic_done: %0d pulses at %0d, expected 1 at %0d", a_done_cnt, a_done_cyc, s + 18);
        end
        vectors++;
        if (a_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_busy_after: got %b, expected 0", a_busy);
        end
    endtask

    task automatic test_hold_lane0();
        int s, n;
        arm_a();
        pulse_start_a(s);
        n = 0;
        while (a_done_cnt == 0 && n < 100) begin
            a_hold[0] = (cyc - s >= 5) && (cyc - s <= 14);
            #1;
            if (cyc - s >= 7 && cyc - s <= 14) begin
                vectors++;
                if (a_rd_en[0] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL hold_full_no_issue cyc%0d: rd_en %b, expected 0", cyc, a_rd_en[0]);
                end
            end
            tick(); n++;
        end
        a_hold = '0;
        repeat (2) tick();
        vectors++;
        if (a_last_acc[1] !== s + 17) begin
            miscompares++;
            $display("FAIL hold_lane1_unaffected: last accept %0d, expected %0d", a_last_acc[1], s + 17);
        end
        vectors++;
        if (a_last_acc[0] !== s + 27 || a_acc[0] !== A_PLANE) begin
            miscompares++;
            $display("FAIL hold_lane0_resume: last accept %0d count %0d, expected %0d count %0d", a_last_acc[0], a_acc[0], s + 27, A_PLANE);
        end
        vectors++;
        if (a_done_cnt !== 1 || a_done_cyc !== s + 28) begin
            miscompares++;
            $display("FAIL hold_done: %0d pulses at %0d, expected 1 at %0d", a_done_cnt, a_done_cyc, s + 28);
        end
    endtask

    task automatic test_reset_midframe();
        int s, n;
        arm_a();
        pulse_start_a(s);
        n = 0;
        while (a_acc[0] < 7 && n < 50) begin tick(); n++; end
        #2;
        a_rst_n = 1'b0;
        #1;
        vectors++;
        if ({a_rd_en, a_addr, a_valid, a_data, a_busy, a_done} !== '0) begin
            miscompares++;
            $display("FAIL midframe_async_reset: got 0x%0h, expected 0", {a_rd_en, a_addr, a_valid, a_data, a_busy, a_done});
        end
        for (int c = 0; c < A_CH; c++) begin a_q[c].delete(); a_held[c] = 1'b0; end
        tick();
        a_rst_n = 1'b1;
        tick();
        arm_a();
        pulse_start_a(s);
        vectors++;
        if (a_rd_en !== 2'b11 || a_addr !== {16'h0110, 16'h0100}) begin
            miscompares++;
            $display("FAIL restart_issue: rd_en %b addr 0x%0h, expected 11 0x01100100", a_rd_en, a_addr);
        end
        n = 0;
        while (a_done_cnt == 0 && n < 100) begin tick(); n++; end
        tick();
        vectors++;
        if (a_done_cnt !== 1 || a_done_cyc !== s + 18 || a_acc[0] !== A_PLANE) begin
            miscompares++;
            $display("FAIL restart_done: %0d pulses at %0d lane0 %0d, expected 1 at %0d lane0 %0d",
                     a_done_cnt, a_done_cyc, a_acc[0], s + 18, A_PLANE);
        end
    endtask

    task automatic test_start_ignored();
        int s, n;
        arm_a();
        pulse_start_a(s);
        n = 0;
        while (cyc - s <= 22 && n < 100) begin
            a_start = (cyc - s == 5) || (cyc - s == 9) || (cyc - s == 18);
            tick(); n++;
        end
        a_start = 1'b0;
        vectors++;
        if (a_done_cnt !== 1 || a_done_cyc !== s + 18) begin
            miscompares++;
            $display("FAIL restart_ignored_done: %0d pulses at %0d, expected 1 at %0d", a_done_cnt, a_done_cyc, s + 18);
        end
        vectors++;
        if (a_busy !== 1'b0 || a_rd_en !== 2'b00) begin
            miscompares++;
            $display("FAIL restart_ignored_idle: busy %b rd_en %b, expected 0 00", a_busy, a_rd_en);
        end
    endtask

    task automatic test_hold_last();
        int s, n;
        arm_a();
        pulse_start_a(s);
        n = 0;
        while (a_done_cnt == 0 && n < 100) begin
            a_hold[1] = (cyc - s >= 17) && (cyc - s <= 36);
            #1;
            if (a_hold[1]) begin
                vectors++;
                if (a_busy !== 1'b1 || a_done !== 1'b0 || a_valid[1] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL hold_last_wait cyc%0d: busy %b done %b valid %b, expected 1 0 1", cyc, a_busy, a_done, a_valid[1]);
                end
            end
            tick(); n++;
        end
        a_hold = '0;
        tick();
        vectors++;
        if (a_done_cnt !== 1 || a_done_cyc !== s + 38 || a_last_acc[1] !== s + 37) begin
            miscompares++;
            $display("FAIL hold_last_done: %0d pulses at %0d last %0d, expected 1 at %0d last %0d",
                     a_done_cnt, a_done_cyc, a_last_acc[1], s + 38, s + 37);
        end
    endtask

    task automatic test_random_hold();
        int s, n, last;
        arm_b();
        b_start = 1'b1; s = cyc;
        tick();
        b_start = 1'b0;
        n = 0;
        while (b_done_cnt == 0 && n < 20000) begin
            b_hold = 3'($urandom_range(0, 7));
            tick(); n++;
        end
        b_hold = '0;
        repeat (3) tick();
        last = 0;
        for (int c = 0; c < B_CH; c++) begin
            if (b_last_acc[c] > last) last = b_last_acc[c];
            vectors++;
            if (b_acc[c] !== B_PLANE || b_q[c].size() !== 0) begin
                miscompares++;
                $display("FAIL random_lane%0d_count: accepted %0d pending %0d, expected %0d and 0", c, b_acc[c], b_q[c].size(), B_PLANE);
            end
        end
        vectors++;
        if (b_done_cnt !== 1 || b_done_cyc !== last + 1) begin
            miscompares++;
            $display("FAIL random_done: %0d pulses at %0d, expected 1 at %0d", b_done_cnt, b_done_cyc, last + 1);
        end
        vectors++;
        if (b_first_valid < s + 2) begin
            miscompares++;
            $display("FAIL random_first_valid: cycle %0d, expected >= %0d", b_first_valid, s + 2);
        end
    endtask

    initial begin
        test_reset();
        test_basic_stream();
        test_hold_lane0();
        test_reset_midframe();
        test_start_ignored();
        test_hold_last();
        test_random_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
